// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register-file write port arbiter with load buffer and busy scoreboard
module writeback_unit #(
   parameter int XLEN     = 32,
   parameter int LD_DEPTH = 2
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            IssueValid,
   input  logic [4:0]      IssueRs1,
   input  logic [4:0]      IssueRs2,
   input  logic [4:0]      IssueRd,
   input  logic            IssueIsLoad,
   output logic            Stall,
   input  logic            AluValid,
   input  logic [4:0]      AluRd,
   input  logic [XLEN-1:0] AluData,
   input  logic            LdValid,
   input  logic [4:0]      LdRd,
   input  logic [XLEN-1:0] LdData,
   output logic            LdReady,
   output logic [4:0]      AddrD,
   output logic [XLEN-1:0] DataD,
   output logic            RegWEn,
   output logic            BypassA,
   output logic            BypassB
);

   localparam int PW = $clog2(LD_DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]     busy_q, busy_d;
   logic [4:0]      buf_rd_q   [LD_DEPTH];
   logic [XLEN-1:0] buf_data_q [LD_DEPTH];
   logic [PW-1:0]   head_q, tail_q;
   logic [CW-1:0]   count_q, count_d;
   logic [4:0]      addr_q, addr_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            wen_q, wen_d;

   logic alu_wr, push, pop, issue_set;

   assign Stall     = IssueValid && (busy_q[IssueRs1] || busy_q[IssueRs2] || busy_q[IssueRd]);
   assign LdReady   = (count_q < CW'(LD_DEPTH));
   assign alu_wr    = AluValid && (AluRd != 5'd0);
   // Rd=0 loads complete the handshake but are never buffered.
   assign push      = LdValid && LdReady && (LdRd != 5'd0);
   assign pop       = !alu_wr && (count_q != '0);
   assign issue_set = IssueValid && !Stall && IssueIsLoad && (IssueRd != 5'd0);

   assign BypassA = wen_q && (addr_q != 5'd0) && (IssueRs1 == addr_q);
   assign BypassB = wen_q && (addr_q != 5'd0) && (IssueRs2 == addr_q);
   assign AddrD   = addr_q;
   assign DataD   = data_q;
   assign RegWEn  = wen_q;

   always_comb begin
      wen_d  = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      busy_d = busy_q;
      if (alu_wr) begin
         wen_d  = 1'b1;
         addr_d = AluRd;
         data_d = AluData;
      end else if (pop) begin
         wen_d  = 1'b1;
         addr_d = buf_rd_q[head_q];
         data_d = buf_data_q[head_q];
         busy_d[buf_rd_q[head_q]] = 1'b0;
      end
      if (issue_set) begin
         busy_d[IssueRd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         busy_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         if (push) begin
            buf_rd_q[tail_q]   <= LdRd;
            buf_data_q[tail_q] <= LdData;
            tail_q             <= tail_q + PW'(1);
         end
         if (pop) begin
            head_q <= head_q + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - randomized and directed bench for writeback_unit against a queue model
module tb_writeback_unit;

   localparam int XLEN     = 32;
   localparam int LD_DEPTH = 2;

   logic            Clk = 1'b0;
   logic            Rst;
   logic            IssueValid, IssueIsLoad;
   logic [4:0]      IssueRs1, IssueRs2, IssueRd;
   logic            Stall;
   logic            AluValid;
   logic [4:0]      AluRd;
   logic [XLEN-1:0] AluData;
   logic            LdValid;
   logic [4:0]      LdRd;
   logic [XLEN-1:0] LdData;
   logic            LdReady;
   logic [4:0]      AddrD;
   logic [XLEN-1:0] DataD;
   logic            RegWEn, BypassA, BypassB;

   writeback_unit #(.XLEN(XLEN), .LD_DEPTH(LD_DEPTH)) dut (
      .Clk(Clk), .Rst(Rst),
      .IssueValid(IssueValid), .IssueRs1(IssueRs1), .IssueRs2(IssueRs2),
      .IssueRd(IssueRd), .IssueIsLoad(IssueIsLoad), .Stall(Stall),
      .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData),
      .LdValid(LdValid), .LdRd(LdRd), .LdData(LdData), .LdReady(LdReady),
      .AddrD(AddrD), .DataD(DataD), .RegWEn(RegWEn),
      .BypassA(BypassA), .BypassB(BypassB)
   );

   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;

   // Reference state: busy set, pending load FIFO as a queue, and the expected write port.
   logic [31:0]     m_busy;
   logic [4:0]      m_qrd   [$];
   logic [XLEN-1:0] m_qdata [$];
   logic            m_wen;
   logic [4:0]      m_addr;
   logic [XLEN-1:0] m_data;
   logic [4:0]      pend [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_stall();
      return IssueValid && (m_busy[IssueRs1] || m_busy[IssueRs2] || m_busy[IssueRd]);
   endfunction

   function automatic logic m_ready();
      return m_qrd.size() < LD_DEPTH;
   endfunction

   task automatic model_reset();
      m_busy = '0;
      m_qrd.delete();
      m_qdata.delete();
      m_wen  = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   task automatic idle();
      Rst = 0; IssueValid = 0; IssueIsLoad = 0;
      IssueRs1 = 0; IssueRs2 = 0; IssueRd = 0;
      AluValid = 0; AluRd = 0; AluData = 0;
      LdValid = 0; LdRd = 0; LdData = 0;
   endtask

   task automatic step();
      logic stall_now, ready_now;
      @(negedge Clk);
      stall_now = m_stall();
      ready_now = m_ready();
      check("Stall",   Stall,   stall_now);
      check("LdReady", LdReady, ready_now);
      check("RegWEn",  RegWEn,  m_wen);
      check("AddrD",   AddrD,   m_addr);
      check("DataD",   DataD,   m_data);
      check("BypassA", BypassA, m_wen && m_addr != 0 && IssueRs1 == m_addr);
      check("BypassB", BypassB, m_wen && m_addr != 0 && IssueRs2 == m_addr);
      if (m_wen) check("no_wr_r0", (AddrD != 0), 1);
      if (Rst) begin
         model_reset();
      end else begin
         if (AluValid && AluRd != 0) begin
            m_wen = 1; m_addr = AluRd; m_data = AluData;
         end else if (m_qrd.size() > 0) begin
            m_wen  = 1;
            m_addr = m_qrd.pop_front();
            m_data = m_qdata.pop_front();
            m_busy[m_addr] = 1'b0;
         end else begin
            m_wen = 0;
         end
         if (LdValid && ready_now && LdRd != 0) begin
            m_qrd.push_back(LdRd);
            m_qdata.push_back(LdData);
         end
         if (IssueValid && !stall_now && IssueIsLoad && IssueRd != 0)
            m_busy[IssueRd] = 1'b1;
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      idle();
      // Registers are unknown before the first edge, so the first reset cycle is unchecked.
      Rst = 1; AluValid = 1; AluRd = 5; AluData = 32'h1111;
      @(posedge Clk); #1;
      model_reset();

      // Reset held with ALU active
      step(); step();
      idle();
      step();
      check("reset_release_wen", RegWEn, 0);

      // ALU write and bypass
      AluValid = 1; AluRd = 5; AluData = 32'hDEADBEEF;
      step();
      idle(); IssueRs1 = 5; IssueRs2 = 6;
      step();
      check("alu_addr", AddrD, 5);
      check("alu_data", DataD, 32'hDEADBEEF);

      // Load RAW stall and release
      idle(); IssueValid = 1; IssueIsLoad = 1; IssueRd = 7;
      step();
      idle(); IssueValid = 1; IssueRs2 = 7; IssueRd = 1;
      LdValid = 1; LdRd = 7; LdData = 32'h12;
      step();
      LdValid = 0;
      step();
      step();
      check("ld_port_addr", AddrD, 7);
      check("ld_port_data", DataD, 32'h12);

      // Two buffered loads behind three ALU writes
      idle(); IssueValid = 1; IssueIsLoad = 1; IssueRd = 3; step();
      IssueRd = 4; step();
      idle(); AluValid = 1; AluRd = 9;  AluData = 9;  LdValid = 1; LdRd = 3; LdData = 3; step();
      AluRd = 10; AluData = 10; LdRd = 4; LdData = 4; step();
      check("full_ready", LdReady, 0);
      AluRd = 11; AluData = 11; LdRd = 5; LdData = 5; step();
      idle();
      for (int i = 0; i < 4; i++) step();

      // Rd=0 for ALU and issued load; buffered load drains under ALU rd0
      idle(); IssueValid = 1; IssueIsLoad = 1; IssueRd = 0; AluValid = 1; AluRd = 0; step();
      idle(); IssueValid = 1; IssueIsLoad = 1; IssueRd = 6; step();
      idle(); LdValid = 1; LdRd = 6; LdData = 32'h66; AluValid = 1; AluRd = 12; AluData = 1; step();
      idle(); AluValid = 1; AluRd = 0; AluData = 32'hBAD; step();
      check("rd0_drain_addr", AddrD, 6);
      idle(); step(); step();

      // Reset with buffered loads and busy registers
      idle(); IssueValid = 1; IssueIsLoad = 1; IssueRd = 3; step();
      IssueRd = 8; step();
      idle(); AluValid = 1; AluRd = 12; LdValid = 1; LdRd = 3; LdData = 32'h33; step();
      AluRd = 13; LdRd = 8; LdData = 32'h88; step();
      idle(); Rst = 1; AluValid = 1; AluRd = 14; step();
      idle(); IssueValid = 1; IssueRs1 = 3; step();
      check("post_rst_stall", Stall, 0);
      check("post_rst_ready", LdReady, 1);
      idle(); step(); step();

      // Randomized traffic: loads offered only for registers actually issued as loads
      pend.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic stall_pre, ready_pre;
         Rst         = ($urandom_range(0, 249) == 0);
         IssueValid  = $urandom_range(0, 1);
         IssueIsLoad = $urandom_range(0, 1);
         IssueRs1    = 5'($urandom);
         IssueRs2    = 5'($urandom);
         IssueRd     = 5'($urandom);
         LdValid     = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
         LdRd        = (pend.size() > 0) ? pend[0] : 5'd0;
         LdData      = $urandom;
         AluValid    = $urandom_range(0, 1);
         AluRd       = 5'($urandom);
         if (m_busy[AluRd]) AluRd = 0;
         AluData     = $urandom;
         stall_pre   = m_stall();
         ready_pre   = m_ready();
         step();
         if (Rst) begin
            pend.delete();
         end else begin
            if (LdValid && ready_pre) void'(pend.pop_front());
            if (IssueValid && !stall_pre && IssueIsLoad && IssueRd != 0) pend.push_back(IssueRd);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
